// File: rtl/rom_addr_sequencer_pkg.sv
// Shared definitions for the ROM address sequencer: the default address width
// and the run/pause state encoding.
package rom_addr_sequencer_pkg;

   localparam int ADDR_W_DEFAULT = 11;

   typedef enum logic [1:0] {
      RUN_UP   = 2'd0,
      RUN_DOWN = 2'd1,
      PAUSE    = 2'd2
   } seqState_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, counter debounce and
// rising-edge detect producing a one-cycle Press pulse.
module btn_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic Clk,
   input  logic Rst,
   input  logic BtnIn,
   output logic Press
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic             debLevel;
   logic             debLevelDly;
   logic [CNT_W-1:0] stableCnt;

   // Bring the raw button into the Clk domain before anything looks at it.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= BtnIn;
         sync2 <= sync1;
      end
   end

   // Count consecutive cycles the synchronized level disagrees with the
   // accepted level; any agreement restarts the count, so glitches vanish.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         debLevel  <= 1'b0;
         stableCnt <= '0;
      end else if (sync2 == debLevel) begin
         stableCnt <= '0;
      end else if (stableCnt == CNT_LAST) begin
         debLevel  <= sync2;
         stableCnt <= '0;
      end else begin
         stableCnt <= stableCnt + CNT_W'(1);
      end
   end

   // Delayed copy of the accepted level for edge detection.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         debLevelDly <= 1'b0;
      end else begin
         debLevelDly <= debLevel;
      end
   end

   assign Press = debLevel & ~debLevelDly;

endmodule

// File: rtl/rom_addr_sequencer.sv
// Steps a ROM address through a window on each ClkEnable tick, either
// wrapping or bouncing at the ends, with a debounced pause/resume button.
module rom_addr_sequencer
   import rom_addr_sequencer_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEFAULT,
   parameter int START_ADDR = 0,
   parameter int END_ADDR   = 31,
   parameter int PINGPONG   = 0,
   parameter int DEB_CYCLES = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              ClkEnable,
   input  logic              BtnIn,
   output logic [ADDR_W-1:0] Address,
   output logic              Paused,
   output logic              Wrap
);

   localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);

   seqState_e         stateQ,   stateNext;
   logic [ADDR_W-1:0] addrQ,    addrNext;
   logic              savedUpQ, savedUpNext;
   logic              wrapQ,    wrapNext;
   logic              press;

   btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) uDebounce (
      .Clk  (Clk),
      .Rst  (Rst),
      .BtnIn(BtnIn),
      .Press(press)
   );

   // State, address, saved direction and the Wrap pulse are all registered.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         stateQ   <= RUN_UP;
         addrQ    <= START_A;
         savedUpQ <= 1'b1;
         wrapQ    <= 1'b0;
      end else begin
         stateQ   <= stateNext;
         addrQ    <= addrNext;
         savedUpQ <= savedUpNext;
         wrapQ    <= wrapNext;
      end
   end

   // A press takes priority over a tick, so the address never moves in the
   // cycle the sequencer is paused or resumed.
   always_comb begin
      stateNext   = stateQ;
      addrNext    = addrQ;
      savedUpNext = savedUpQ;
      wrapNext    = 1'b0;
      case (stateQ)
         RUN_UP: begin
            if (press) begin
               stateNext   = PAUSE;
               savedUpNext = 1'b1;
            end else if (ClkEnable) begin
               if (addrQ == END_A) begin
                  wrapNext = 1'b1;
                  if (PINGPONG != 0) begin
                     stateNext = RUN_DOWN;
                     addrNext  = END_A - ADDR_W'(1);
                  end else begin
                     addrNext = START_A;
                  end
               end else begin
                  addrNext = addrQ + ADDR_W'(1);
               end
            end
         end
         RUN_DOWN: begin
            if (press) begin
               stateNext   = PAUSE;
               savedUpNext = 1'b0;
            end else if (ClkEnable) begin
               if (addrQ == START_A) begin
                  wrapNext  = 1'b1;
                  stateNext = RUN_UP;
                  addrNext  = START_A + ADDR_W'(1);
               end else begin
                  addrNext = addrQ - ADDR_W'(1);
               end
            end
         end
         PAUSE: begin
            if (press) begin
               stateNext = savedUpQ ? RUN_UP : RUN_DOWN;
            end
         end
         default: begin
            stateNext = RUN_UP;
         end
      endcase
   end

   assign Address = addrQ;
   assign Paused  = (stateQ == PAUSE);
   assign Wrap    = wrapQ;

endmodule

// File: tb/tb_rom_addr_sequencer.sv
// Self-checking bench: three sequencer configurations share one stimulus and
// are compared every cycle against a behavioural model, plus directed checks.
module tb_rom_addr_sequencer;

   localparam int ADDR_W = 11;
   localparam int DEB    = 4;
   localparam int N      = 3;

   logic              clk;
   logic              rstN;
   logic              clkEnable;
   logic              btnIn;
   logic [ADDR_W-1:0] obsAddr   [N];
   logic              obsPaused [N];
   logic              obsWrap   [N];

   // Configurations: 0 = bounce over 0..31, 1 = wrap over 0..31, 2 = bounce over 0..3
   int cStart [N] = '{0, 0, 0};
   int cEnd   [N] = '{31, 31, 3};
   int cPing  [N] = '{1, 0, 1};

   int mAddr    [N];
   bit mUp      [N];
   bit mSavedUp [N];
   bit mPaused  [N];
   bit mWrap    [N];
   bit mDeb;
   bit mPendPress;
   bit btnHist [$];

   int errorCount = 0;
   int checkCount = 0;

   rom_addr_sequencer #(.ADDR_W(ADDR_W), .START_ADDR(0), .END_ADDR(31), .PINGPONG(1), .DEB_CYCLES(DEB))
   dutMain (.Clk(clk), .Rst(rstN), .ClkEnable(clkEnable), .BtnIn(btnIn),
            .Address(obsAddr[0]), .Paused(obsPaused[0]), .Wrap(obsWrap[0]));

   rom_addr_sequencer #(.ADDR_W(ADDR_W), .START_ADDR(0), .END_ADDR(31), .PINGPONG(0), .DEB_CYCLES(DEB))
   dutWrap (.Clk(clk), .Rst(rstN), .ClkEnable(clkEnable), .BtnIn(btnIn),
            .Address(obsAddr[1]), .Paused(obsPaused[1]), .Wrap(obsWrap[1]));

   rom_addr_sequencer #(.ADDR_W(ADDR_W), .START_ADDR(0), .END_ADDR(3), .PINGPONG(1), .DEB_CYCLES(DEB))
   dutBounce (.Clk(clk), .Rst(rstN), .ClkEnable(clkEnable), .BtnIn(btnIn),
              .Address(obsAddr[2]), .Paused(obsPaused[2]), .Wrap(obsWrap[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL timeout: simulation did not finish, observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic void modelReset();
      for (int i = 0; i < N; i++) begin
         mAddr[i]    = cStart[i];
         mUp[i]      = 1'b1;
         mSavedUp[i] = 1'b1;
         mPaused[i]  = 1'b0;
         mWrap[i]    = 1'b0;
      end
      mDeb       = 1'b0;
      mPendPress = 1'b0;
      btnHist.delete();
      for (int j = 0; j < DEB + 2; j++) btnHist.push_back(1'b0);
   endfunction

   function automatic void modelStep(int i, bit press, bit en);
      mWrap[i] = 1'b0;
      if (mPaused[i]) begin
         if (press) begin
            mPaused[i] = 1'b0;
            mUp[i]     = mSavedUp[i];
         end
      end else if (press) begin
         mPaused[i]  = 1'b1;
         mSavedUp[i] = mUp[i];
      end else if (en) begin
         if (mUp[i]) begin
            if (mAddr[i] == cEnd[i]) begin
               mWrap[i] = 1'b1;
               if (cPing[i] != 0) begin
                  mUp[i]   = 1'b0;
                  mAddr[i] = cEnd[i] - 1;
               end else begin
                  mAddr[i] = cStart[i];
               end
            end else begin
               mAddr[i] = mAddr[i] + 1;
            end
         end else begin
            if (mAddr[i] == cStart[i]) begin
               mWrap[i] = 1'b1;
               mUp[i]   = 1'b1;
               mAddr[i] = cStart[i] + 1;
            end else begin
               mAddr[i] = mAddr[i] - 1;
            end
         end
      end
   endfunction

   // The button level accepted by the debouncer flips once the last DEB
   // synchronized samples (button delayed two cycles) all disagree with it.
   function automatic void modelEdge();
      bit allNew;
      bit rose;
      bit press;
      if (!rstN) begin
         modelReset();
      end else begin
         press = mPendPress;
         btnHist.push_back(btnIn);
         if (btnHist.size() > DEB + 2) void'(btnHist.pop_front());
         allNew = 1'b1;
         for (int j = 0; j < DEB; j++) begin
            if (btnHist[btnHist.size() - 3 - j] == mDeb) allNew = 1'b0;
         end
         rose = allNew && !mDeb;
         if (allNew) mDeb = !mDeb;
         mPendPress = rose;
         for (int i = 0; i < N; i++) modelStep(i, press, clkEnable);
      end
   endfunction

   task automatic checkAll();
      for (int i = 0; i < N; i++) begin
         checkOutput($sformatf("addr[%0d]", i), 32'(obsAddr[i]), 32'(mAddr[i]));
         checkOutput($sformatf("paused[%0d]", i), 32'(obsPaused[i]), 32'(mPaused[i]));
         checkOutput($sformatf("wrap[%0d]", i), 32'(obsWrap[i]), 32'(mWrap[i]));
      end
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      modelEdge();
      #1;
      checkAll();
   endtask

   task automatic resetDut();
      rstN = 1'b0;
      applyStimulus();
      applyStimulus();
      rstN = 1'b1;
   endtask

   initial begin
      int bounceAddr [7] = '{1, 2, 3, 2, 1, 0, 1};
      int bounceWrap [7] = '{0, 0, 0, 1, 0, 0, 1};
      bit anyPaused;
      int latency;
      int frozenAddr;
      int holdLeft;

      rstN      = 1'b0;
      clkEnable = 1'b0;
      btnIn     = 1'b0;
      modelReset();
      #2;
      checkOutput("resetAddr", 32'(obsAddr[0]), 32'd0);
      checkOutput("resetPaused", 32'(obsPaused[0]), 32'd0);
      checkOutput("resetWrap", 32'(obsWrap[0]), 32'd0);
      applyStimulus();
      applyStimulus();
      rstN = 1'b1;

      // Wrap and bounce sequences with the tick held high
      clkEnable = 1'b1;
      for (int t = 1; t <= 33; t++) begin
         applyStimulus();
         if (t <= 7) begin
            checkOutput($sformatf("bounceSeq%0d", t), 32'(obsAddr[2]), 32'(bounceAddr[t-1]));
            checkOutput($sformatf("bounceWrap%0d", t), 32'(obsWrap[2]), 32'(bounceWrap[t-1]));
         end
         if (t == 31) begin
            checkOutput("wrapAt31Addr", 32'(obsAddr[1]), 32'd31);
            checkOutput("wrapAt31Pulse", 32'(obsWrap[1]), 32'd0);
         end
         if (t == 32) begin
            checkOutput("wrapTo0Addr", 32'(obsAddr[1]), 32'd0);
            checkOutput("wrapTo0Pulse", 32'(obsWrap[1]), 32'd1);
         end
      end

      // A 3-cycle glitch must not pause
      btnIn = 1'b1;
      repeat (3) applyStimulus();
      btnIn = 1'b0;
      anyPaused = 1'b0;
      repeat (10) begin
         applyStimulus();
         anyPaused |= obsPaused[0];
      end
      checkOutput("glitchIgnored", 32'(anyPaused), 32'd0);

      // A held press pauses within 7 cycles and freezes the address
      btnIn   = 1'b1;
      latency = 0;
      for (int t = 1; t <= 12; t++) begin
         applyStimulus();
         if (obsPaused[0] && latency == 0) latency = t;
         if (t == 10) btnIn = 1'b0;
      end
      checkOutput("pressLatencyOk", 32'(latency > 0 && latency <= 7), 32'd1);
      frozenAddr = mAddr[0];
      repeat (5) applyStimulus();
      checkOutput("pausedFrozen", 32'(obsAddr[0]), 32'(frozenAddr));

      // Press and tick in the same cycle at address 5
      resetDut();
      clkEnable = 1'b1;
      repeat (5) applyStimulus();
      clkEnable = 1'b0;
      btnIn     = 1'b1;
      repeat (6) applyStimulus();
      clkEnable = 1'b1;
      applyStimulus();
      checkOutput("collisionAddr", 32'(obsAddr[0]), 32'd5);
      checkOutput("collisionPaused", 32'(obsPaused[0]), 32'd1);
      btnIn = 1'b0;
      repeat (8) applyStimulus();
      checkOutput("pauseIgnoresTick", 32'(obsAddr[0]), 32'd5);
      clkEnable = 1'b0;
      btnIn     = 1'b1;
      repeat (6) applyStimulus();
      clkEnable = 1'b1;
      applyStimulus();
      checkOutput("resumeNoAdvance", 32'(obsAddr[0]), 32'd5);
      checkOutput("resumePaused", 32'(obsPaused[0]), 32'd0);
      applyStimulus();
      checkOutput("resumeAddr", 32'(obsAddr[0]), 32'd6);
      clkEnable = 1'b0;
      btnIn     = 1'b0;
      repeat (8) applyStimulus();

      // Asynchronous reset mid-run while counting down through 17
      resetDut();
      clkEnable = 1'b1;
      repeat (45) applyStimulus();
      checkOutput("downAt17", 32'(obsAddr[0]), 32'd17);
      #3;
      rstN = 1'b0;
      #1;
      modelReset();
      checkOutput("asyncRstAddr", 32'(obsAddr[0]), 32'd0);
      checkOutput("asyncRstPaused", 32'(obsPaused[0]), 32'd0);
      applyStimulus();
      rstN = 1'b1;
      applyStimulus();
      checkOutput("firstAdvance", 32'(obsAddr[0]), 32'd1);

      // Randomized ticks and button activity
      holdLeft = 0;
      repeat (400) begin
         clkEnable = ($urandom_range(0, 3) == 0);
         if (holdLeft == 0) begin
            btnIn    = 1'($urandom_range(0, 1));
            holdLeft = $urandom_range(1, 12);
         end
         holdLeft--;
         applyStimulus();
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
